// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial pattern generator.
package seq_gen_pkg;

  localparam int PAT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } seq_gen_state_t;

  // Requested lengths beyond the pattern width send the whole pattern.
  function automatic int clamp_len(input int len, input int max_len);
    int res;
    if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Pattern holding register with a bit-index down-counter; presents the selected
// bit registered, and forces it to 0 on cycles where no bit is stepped out.
module seq_shift_reg
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             reload,
  input  logic             advance,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  output logic             cur_bit,
  output logic             last_bit
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  logic [PAT_W-1:0] pat_r, pat_n_s;
  logic [LEN_W-1:0] len_r, len_n_s;
  logic [IDX_W-1:0] idx_r, idx_n_s;
  logic             step_s;

  // Next pattern/index: load latches new inputs, reload restarts at the MSB.
  always_comb begin
    pat_n_s = pat_r;
    len_n_s = len_r;
    idx_n_s = idx_r;
    step_s  = 1'b0;
    if (load) begin
      pat_n_s = pat;
      len_n_s = len;
      idx_n_s = IDX_W'(len - LEN_W'(1));
      step_s  = 1'b1;
    end else if (reload) begin
      idx_n_s = IDX_W'(len_r - LEN_W'(1));
      step_s  = 1'b1;
    end else if (advance) begin
      idx_n_s = idx_r - IDX_W'(1);
      step_s  = 1'b1;
    end else begin
      step_s  = 1'b0;
    end
  end

  // State and registered bit/last-bit outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_r    <= '0;
      len_r    <= '0;
      idx_r    <= '0;
      cur_bit  <= 1'b0;
      last_bit <= 1'b0;
    end else begin
      pat_r    <= pat_n_s;
      len_r    <= len_n_s;
      idx_r    <= idx_n_s;
      cur_bit  <= step_s ? pat_n_s[idx_n_s] : 1'b0;
      last_bit <= (idx_n_s == IDX_W'(0));
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: streams a latched pattern MSB-first, repeated a
// programmable number of times with an optional idle gap between repetitions.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rep_cnt
);

  seq_gen_state_t   state_r, state_n_s;
  logic [CNT_W-1:0] reps_r, reps_n_s, rep_cnt_n_s, rep_inc_s;
  logic [GAP_W-1:0] gap_r, gap_n_s, gap_cnt_r, gap_cnt_n_s;
  logic [LEN_W-1:0] len_c_s;
  logic             load_s, reload_s, advance_s, last_s;
  logic             valid_n_s, busy_n_s, done_n_s;

  assign len_c_s   = LEN_W'(clamp_len(int'(len), PAT_W));
  assign rep_inc_s = rep_cnt + CNT_W'(1);

  seq_shift_reg #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .reload  (reload_s),
    .advance (advance_s),
    .pat     (pat),
    .len     (len_c_s),
    .cur_bit (x),
    .last_bit(last_s)
  );

  // Next-state and next-output logic; outputs describe the cycle after the edge.
  always_comb begin
    state_n_s   = state_r;
    reps_n_s    = reps_r;
    gap_n_s     = gap_r;
    gap_cnt_n_s = gap_cnt_r;
    rep_cnt_n_s = rep_cnt;
    valid_n_s   = 1'b0;
    busy_n_s    = 1'b0;
    done_n_s    = 1'b0;
    load_s      = 1'b0;
    reload_s    = 1'b0;
    advance_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !stop && (len != LEN_W'(0))) begin
          state_n_s   = SHIFT;
          reps_n_s    = reps;
          gap_n_s     = gap;
          rep_cnt_n_s = CNT_W'(0);
          load_s      = 1'b1;
          valid_n_s   = 1'b1;
          busy_n_s    = 1'b1;
        end else begin
          state_n_s   = IDLE;
        end
      end
      SHIFT: begin
        if (stop) begin
          state_n_s = IDLE;
        end else if (!last_s) begin
          advance_s = 1'b1;
          valid_n_s = 1'b1;
          busy_n_s  = 1'b1;
        end else begin
          rep_cnt_n_s = rep_inc_s;
          if ((reps_r != CNT_W'(0)) && (rep_inc_s == reps_r)) begin
            state_n_s = IDLE;
            done_n_s  = 1'b1;
          end else if (gap_r != GAP_W'(0)) begin
            state_n_s   = GAP;
            gap_cnt_n_s = gap_r;
            busy_n_s    = 1'b1;
          end else begin
            reload_s  = 1'b1;
            valid_n_s = 1'b1;
            busy_n_s  = 1'b1;
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_n_s = IDLE;
        end else if (gap_cnt_r == GAP_W'(1)) begin
          state_n_s = SHIFT;
          reload_s  = 1'b1;
          valid_n_s = 1'b1;
          busy_n_s  = 1'b1;
        end else begin
          gap_cnt_n_s = gap_cnt_r - GAP_W'(1);
          busy_n_s    = 1'b1;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // FSM, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      reps_r    <= '0;
      gap_r     <= '0;
      gap_cnt_r <= '0;
      rep_cnt   <= '0;
      x_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      reps_r    <= reps_n_s;
      gap_r     <= gap_n_s;
      gap_cnt_r <= gap_cnt_n_s;
      rep_cnt   <= rep_cnt_n_s;
      x_valid   <= valid_n_s;
      busy      <= busy_n_s;
      done      <= done_n_s;
    end
  end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern generator: the transmit-side companion to the team's serial sequence detectors. It latches a parallel pattern and shifts it out one bit per clock, MSB-first, over a programmable length. It repeats the pattern a programmable number of times, with an optional idle gap between repetitions. It drives the single-bit `x` stimulus/data line that the detectors consume, both in benches and in on-chip self-test paths.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits.
- `LEN_W`, default `$clog2(PAT_W+1)`: width of `len`.
- `CNT_W`, default 4: width of `reps` and `rep_cnt`.
- `GAP_W`, default 4: width of `gap`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request a transfer; sampled only in IDLE.
- `stop` in 1: abort the current transfer.
- `pat` in `PAT_W`: pattern; bits `pat[len-1]` down to `pat[0]` are sent.
- `len` in `LEN_W`: bits per repetition (1..`PAT_W`).
- `reps` in `CNT_W`: repetition count; 0 means continuous until `stop`.
- `gap` in `GAP_W`: idle cycles between repetitions.
- `x` out 1: serial bit; 0 whenever `x_valid`=0.
- `x_valid` out 1: `x` carries a pattern bit this cycle.
- `busy` out 1: a transfer is in progress (SHIFT or GAP).
- `done` out 1: one-cycle pulse after the last bit of the last repetition.
- `rep_cnt` out `CNT_W`: completed repetitions of the current/last transfer.

## Operation
- FSM has three states: IDLE, SHIFT, GAP. Reset state is IDLE.
- All outputs are registered. Reset values: `x`=0, `x_valid`=0, `busy`=0, `done`=0, `rep_cnt`=0.
- IDLE → SHIFT on `start`=1, `stop`=0, `len`≠0.
  - `pat`, `len`, `reps` and `gap` are latched at this edge.
  - `rep_cnt` clears to 0.
  - `len`>`PAT_W` is clamped to `PAT_W`.
  - `len`=0: `start` is ignored and the block stays IDLE.
- SHIFT: a bit index runs from `len-1` down to 0, one bit per cycle; `x`=`pat[idx]` and `x_valid`=1.
- After bit 0, `rep_cnt` increments (wraps modulo 2^`CNT_W`). Then:
  - Last repetition (`rep_cnt+1`=`reps`, `reps`≠0) → IDLE, `done` pulses.
  - Otherwise, `gap`>0 → GAP.
  - Otherwise, `gap`=0 → SHIFT restarts at `len-1`, back-to-back with no bubble.
- GAP: `x`=0 and `x_valid`=0 for exactly `gap` cycles, then → SHIFT at `len-1`.
- `stop`=1 in SHIFT or GAP → IDLE at the next edge.
  - `x_valid` and `busy` drop.
  - `done` is not asserted; `rep_cnt` holds.
- `start` while `busy` is ignored. Input changes after the latch have no effect on the transfer.
- `stop` and `start` together in IDLE: `stop` wins and nothing starts.
- `start` in the same cycle `done` is high is accepted, because the state is already IDLE.
- Asserting `rst` at any point clears all state and outputs immediately.

## Timing
- `start` sampled at edge E0 → first bit (`pat[len-1]`) on `x` with `x_valid`=1 during the cycle after E0 (latency 1).
- Bit k of repetition r (k=0 is the first bit sent) is presented after edge E0 + r·(`len`+`gap`) + k.
- Final repetition R=`reps`−1:
  - `done`=1 and `busy`=0 after edge E0 + R·(`len`+`gap`) + `len`.
  - `busy`=1 from the cycle after E0 through the last bit cycle inclusive.
- `stop` sampled at edge Es → `x_valid`=0 and `busy`=0 after Es.
- Deassertion of `rst` is synchronised externally; the block requires no recovery cycles.

## Structure
- Package `seq_gen_pkg` holds:
  - the FSM state typedef `seq_gen_state_t` {IDLE, SHIFT, GAP};
  - a localparam default for `PAT_W`;
  - a helper function for length clamping.
- Sub-module `seq_shift_reg`: loadable `PAT_W` shift register with a bit-index down-counter; it outputs the current bit and a last-bit flag.
- The top level holds the FSM, the repetition counter and the gap counter.

## Test plan
- `pat`=8'h05, `len`=3, `reps`=1, `gap`=0 → `x` = 1,0,1 on three consecutive valid cycles, then `done` pulses once and `rep_cnt`=1.
- `pat`=8'h05, `len`=3, `reps`=3, `gap`=2 → the 1,0,1 pattern three times, with exactly 2 invalid cycles between repetitions; `done` comes 13 cycles after start and `rep_cnt`=3.
- `reps`=0, `gap`=0, `pat`=8'h0B, `len`=4 → a continuous stream 1011 1011 …; `stop` after 6 bits → `x_valid`=0 next cycle, no `done`, `rep_cnt`=1.
- `len`=0 with `start`, then `len`=12 with `PAT_W`=8 → the first is ignored (`busy` stays 0); the second sends 8 bits.
- `start` asserted while `busy`, and `pat` changed mid-transfer → neither affects the output sequence.
- `rst` pulled low mid-SHIFT → all outputs are 0 immediately; after release the block is IDLE and a new `start` works with latency 1.
